// File: rtl/dance_game_pkg.sv
// Shared types and constants for the dance-off round controller and its datapath peers.
package dance_game_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StCountdown = 2'd1,
        StPlay      = 2'd2,
        StOver      = 2'd3
    } state_e;

    localparam int unsigned ARROW_W    = 4;
    localparam int unsigned TIMER_W    = 20;
    localparam int unsigned BEAT_CNT_W = 7;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    // Galois feedback mask for taps 16,14,13,11 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    function automatic logic [ARROW_W-1:0] arrow_onehot(input logic [1:0] sel);
        return ARROW_W'(1) << sel;
    endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// 16-bit Galois LFSR used as the arrow-pattern entropy source; reusable by sound/visual blocks.
module pattern_lfsr
    import dance_game_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        advance,
    input  logic        load_seed,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_next;

    always_comb begin
        value_next = {1'b0, value_q[15:1]} ^ (value_q[0] ? LFSR_TAPS : 16'h0000);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_q <= SEED;
        end else if (load_seed) begin
            value_q <= SEED;
        end else if (advance) begin
            value_q <= value_next;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/dance_game_sequencer.sv
// Round controller for a dance-off: idle -> countdown -> play -> over, with beat-grid patterns.
// Optional DANCE_DOUBLE_STEP_EN adds a rotate-by-2 second arrow on every 4th play beat.
module dance_game_sequencer
    import dance_game_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 32,
    parameter int unsigned BEAT_TICKS      = 781250,
    parameter int unsigned VALID_TICKS     = 625000,
    parameter int unsigned COUNTDOWN_BEATS = 4,
    parameter int unsigned NUM_BEATS       = 64,
    parameter logic [15:0] SEED            = DEFAULT_SEED
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic                  game_active,
    output logic                  game_over,
    output logic [ARROW_W-1:0]    pattern_a,
    output logic [ARROW_W-1:0]    pattern_b,
    output logic                  pattern_valid,
    output logic [TIMER_W-1:0]    pattern_timer,
    output logic [BEAT_CNT_W-1:0] beat_count,
    output logic [1:0]            state
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (NUM_BEATS < 1 || NUM_BEATS > 127) begin : g_bad_num_beats
        $error("NUM_BEATS must be within 1..127");
    end

    state_e                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [BEAT_CNT_W-1:0] beat_q, beat_d;
    logic [ARROW_W-1:0]    pat_a_q, pat_a_d, pat_b_q, pat_b_d;
    logic                  valid_q, valid_d;
    logic                  start_q, armed_q;
    logic                  start_rise, running, tick, beat_end, load, lfsr_adv;
    logic [15:0]           lfsr_value;
    logic [11:0]           lfsr_unused;

    pattern_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clock     (clock),
        .reset     (reset),
        .advance   (lfsr_adv),
        .load_seed (1'b0),
        .value     (lfsr_value)
    );

    assign lfsr_unused = lfsr_value[15:4];

    // armed_q masks the first cycle out of reset so a start held through reset is not an edge.
    assign start_rise = start & ~start_q & armed_q;
    assign running    = (state_q == StCountdown) || (state_q == StPlay);
    assign tick       = running && (div_q == DIV_W'(TICK_DIV - 1));
    assign beat_end   = tick && (timer_q == TIMER_W'(BEAT_TICKS - 1));

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        timer_d  = timer_q;
        beat_d   = beat_q;
        pat_a_d  = pat_a_q;
        pat_b_d  = pat_b_q;
        load     = 1'b0;
        lfsr_adv = 1'b0;

        if (running) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                timer_d = beat_end ? '0 : timer_q + TIMER_W'(1);
            end
            if (beat_end && beat_q != '1) begin
                beat_d = beat_q + BEAT_CNT_W'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                lfsr_adv = 1'b1;
                if (start_rise) begin
                    state_d = StCountdown;
                    div_d   = '0;
                    timer_d = '0;
                    beat_d  = '0;
                end
            end
            StCountdown: begin
                if (beat_end && beat_q == BEAT_CNT_W'(COUNTDOWN_BEATS - 1)) begin
                    state_d = StPlay;
                    beat_d  = '0;
                    load    = 1'b1;
                end
            end
            StPlay: begin
                if (beat_end) begin
                    if (beat_q == BEAT_CNT_W'(NUM_BEATS - 1)) begin
                        state_d = StOver;
                        beat_d  = BEAT_CNT_W'(NUM_BEATS);
                        pat_a_d = '0;
                        pat_b_d = '0;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            StOver: begin
                if (start_rise) begin
                    state_d = StCountdown;
                    div_d   = '0;
                    timer_d = '0;
                    beat_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            pat_a_d  = arrow_onehot(lfsr_value[1:0]);
            pat_b_d  = arrow_onehot(lfsr_value[3:2]);
`ifdef DANCE_DOUBLE_STEP_EN
            if (beat_d[1:0] == 2'b11) begin
                pat_a_d = pat_a_d | {pat_a_d[1:0], pat_a_d[3:2]};
                pat_b_d = pat_b_d | {pat_b_d[1:0], pat_b_d[3:2]};
            end
`endif
            lfsr_adv = 1'b1;
        end

        if (abort && state_q != StIdle) begin
            state_d  = StIdle;
            div_d    = '0;
            timer_d  = '0;
            beat_d   = '0;
            pat_a_d  = '0;
            pat_b_d  = '0;
            lfsr_adv = 1'b0;
        end

        valid_d = (state_d == StPlay) && ({1'b0, timer_d} < (TIMER_W + 1)'(VALID_TICKS));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            div_q   <= '0;
            timer_q <= '0;
            beat_q  <= '0;
            pat_a_q <= '0;
            pat_b_q <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            timer_q <= timer_d;
            beat_q  <= beat_d;
            pat_a_q <= pat_a_d;
            pat_b_q <= pat_b_d;
            valid_q <= valid_d;
            start_q <= start;
            armed_q <= 1'b1;
        end
    end

    assign game_active   = (state_q == StPlay);
    assign game_over     = (state_q == StOver);
    assign pattern_a     = pat_a_q;
    assign pattern_b     = pat_b_q;
    assign pattern_valid = valid_q;
    assign pattern_timer = timer_q;
    assign beat_count    = beat_q;
    assign state         = state_q;

endmodule

// File: tb/tb_dance_game_sequencer.sv
// Directed bench for dance_game_sequencer with a reference LFSR for the expected arrow patterns.
module tb_dance_game_sequencer;
    import dance_game_pkg::*;

    localparam int unsigned TICK_DIV        = 1;
    localparam int unsigned BEAT_TICKS      = 8;
    localparam int unsigned VALID_TICKS     = 6;
    localparam int unsigned COUNTDOWN_BEATS = 2;
    localparam int unsigned NUM_BEATS       = 4;
    localparam logic [15:0] TB_SEED         = 16'hACE1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b1;
    logic        abort = 1'b0;
    logic        game_active, game_over, pattern_valid;
    logic [3:0]  pattern_a, pattern_b;
    logic [19:0] pattern_timer;
    logic [6:0]  beat_count;
    logic [1:0]  state;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] m_lfsr;
    bit          idle_model;

    always #5 clock = ~clock;

    dance_game_sequencer #(
        .TICK_DIV        (TICK_DIV),
        .BEAT_TICKS      (BEAT_TICKS),
        .VALID_TICKS     (VALID_TICKS),
        .COUNTDOWN_BEATS (COUNTDOWN_BEATS),
        .NUM_BEATS       (NUM_BEATS),
        .SEED            (TB_SEED)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .game_active   (game_active),
        .game_over     (game_over),
        .pattern_a     (pattern_a),
        .pattern_b     (pattern_b),
        .pattern_valid (pattern_valid),
        .pattern_timer (pattern_timer),
        .beat_count    (beat_count),
        .state         (state)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic logic [3:0] exp_arrow(input logic [1:0] sel, input int beat);
        logic [3:0] p;
        p = 4'b0001 << sel;
`ifdef DANCE_DOUBLE_STEP_EN
        if (beat % 4 == 3) p = p | {p[1:0], p[3:2]};
`endif
        return p;
    endfunction

    function automatic int exp_pop(input int beat);
`ifdef DANCE_DOUBLE_STEP_EN
        return (beat % 4 == 3) ? 2 : 1;
`else
        return (beat >= 0) ? 1 : 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        if (idle_model) m_lfsr = lfsr_next(m_lfsr);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_active"}, 32'(game_active), 32'd0);
        check({tag, "_over"}, 32'(game_over), 32'd0);
        check({tag, "_pat_a"}, 32'(pattern_a), 32'd0);
        check({tag, "_pat_b"}, 32'(pattern_b), 32'd0);
        check({tag, "_valid"}, 32'(pattern_valid), 32'd0);
        check({tag, "_timer"}, 32'(pattern_timer), 32'd0);
        check({tag, "_beat"}, 32'(beat_count), 32'd0);
    endtask

    task automatic check_pattern(input string tag, input int beat);
        check({tag, "_pat_a"}, 32'(pattern_a), 32'(exp_arrow(m_lfsr[1:0], beat)));
        check({tag, "_pat_b"}, 32'(pattern_b), 32'(exp_arrow(m_lfsr[3:2], beat)));
        check({tag, "_pop_a"}, 32'($countones(pattern_a)), 32'(exp_pop(beat)));
        check({tag, "_pop_b"}, 32'($countones(pattern_b)), 32'(exp_pop(beat)));
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    initial begin
        m_lfsr     = TB_SEED;
        idle_model = 1'b0;

        #12;
        check_cleared("reset");
        #10;
        reset      = 1'b1;
        idle_model = 1'b1;
        steps(3);
        check("start_held_no_edge", 32'(state), 32'd0);

        start = 1'b0;
        step();
        start = 1'b1;
        step();
        idle_model = 1'b0;
        check("cd_entry_state", 32'(state), 32'd1);
        check("cd_entry_timer", 32'(pattern_timer), 32'd0);
        check("cd_entry_beat", 32'(beat_count), 32'd0);

        steps(8);
        check("cd_beat1_state", 32'(state), 32'd1);
        check("cd_beat1_count", 32'(beat_count), 32'd1);
        check("cd_pat_a_zero", 32'(pattern_a), 32'd0);
        check("cd_active", 32'(game_active), 32'd0);
        check("cd_valid", 32'(pattern_valid), 32'd0);

        steps(8);
        check("play_entry_state", 32'(state), 32'd2);
        check("play_entry_active", 32'(game_active), 32'd1);
        check("play_entry_timer", 32'(pattern_timer), 32'd0);
        check("play_entry_valid", 32'(pattern_valid), 32'd1);

        for (int b = 0; b < 4; b++) begin
            check($sformatf("play_b%0d_count", b), 32'(beat_count), 32'(b));
            check_pattern($sformatf("play_b%0d", b), b);
            for (int t = 1; t < 8; t++) begin
                step();
                check($sformatf("b%0d_timer%0d", b, t), 32'(pattern_timer), 32'(t));
                check($sformatf("b%0d_valid%0d", b, t), 32'(pattern_valid),
                      (t < 6) ? 32'd1 : 32'd0);
            end
            step();
        end

        check("over_state", 32'(state), 32'd3);
        check("over_flag", 32'(game_over), 32'd1);
        check("over_active", 32'(game_active), 32'd0);
        check("over_beat", 32'(beat_count), 32'd4);
        check("over_pat_a", 32'(pattern_a), 32'd0);
        check("over_pat_b", 32'(pattern_b), 32'd0);
        check("over_valid", 32'(pattern_valid), 32'd0);
        check("over_timer", 32'(pattern_timer), 32'd0);
        steps(2);
        check("over_hold_state", 32'(state), 32'd3);
        check("over_hold_beat", 32'(beat_count), 32'd4);

        start = 1'b0;
        step();
        start = 1'b1;
        step();
        check("round2_state", 32'(state), 32'd1);
        check("round2_over", 32'(game_over), 32'd0);
        check("round2_beat", 32'(beat_count), 32'd0);
        steps(16);
        check("round2_play", 32'(state), 32'd2);
        check_pattern("round2_b0", 0);
        start = 1'b0;
        steps(3);
        check("abort_pre_timer", 32'(pattern_timer), 32'd3);

        abort = 1'b1;
        start = 1'b1;
        step();
        idle_model = 1'b1;
        check_cleared("abort");
        abort = 1'b0;
        steps(2);
        check("post_abort_idle", 32'(state), 32'd0);

        start = 1'b0;
        step();
        start = 1'b1;
        step();
        idle_model = 1'b0;
        check("restart_state", 32'(state), 32'd1);
        steps(5);
        check("restart_timer", 32'(pattern_timer), 32'd5);

        #2;
        reset = 1'b0;
        #1;
        check_cleared("async_reset");
        check("async_reset_lfsr", 32'(dut.u_lfsr.value), 32'(TB_SEED));
        m_lfsr = TB_SEED;
        #3;
        reset      = 1'b1;
        idle_model = 1'b1;
        steps(2);
        check("post_reset_idle", 32'(state), 32'd0);
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        idle_model = 1'b0;
        steps(16);
        check("post_reset_play", 32'(state), 32'd2);
        check_pattern("post_reset_b0", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
